fft_twiddle_fetch: RTL and testbench
====================================

Name: fft_twiddle_fetch

Overview:
- Read-side sequencer for the 1024-point FFT twiddle ROM.
- On a start pulse it walks every radix-2 DIT stage and butterfly, and computes the twiddle index for each one.
- It drives the ROM's en/addr port and realigns the 1-cycle-latency ROM data.
- It delivers each {real,imag} twiddle, tagged with stage and butterfly index, to the butterfly datapath over a valid/ready stream with full backpressure.

Parameters:
- TWIDDLE_WIDTH, 64, packed twiddle width {real[W/2-1:0], imag[W/2-1:0]}.
- ADDR_WIDTH, 8, ROM address MSB index; ROM address is ADDR_WIDTH+1 bits (512 entries).
- LOG2N, 10, log2 of FFT size; must equal ADDR_WIDTH+2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a full twiddle sweep; ignored unless idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last stream transfer.
- tw_en  out  1  ROM read enable.
- tw_addr  out  ADDR_WIDTH+1  ROM address.
- tw_data  in  TWIDDLE_WIDTH  ROM data, valid on the cycle after tw_en.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_twiddle  out  TWIDDLE_WIDTH  twiddle word.
- m_stage  out  4  stage index 0..LOG2N-1.
- m_bfly  out  ADDR_WIDTH+1  butterfly index 0..2^(LOG2N-1)-1.
- m_last  out  1  high on the final word (stage LOG2N-1, bfly 511).

Behaviour:
- Reset state: all outputs are 0; FSM=IDLE; counters, FIFO and in-flight flag are cleared.
- An asserted rst aborts any sweep immediately. No done is produced for an aborted sweep.

FSM:
- IDLE: start=1 -> RUN, with stage=0 and bfly=0.
- RUN: issues reads. After issuing (stage=LOG2N-1, bfly=511) -> DRAIN.
- DRAIN: no issue. When the m_last transfer occurs (m_valid & m_ready & m_last) -> IDLE and done=1 for one cycle.
- busy=1 in RUN and DRAIN. start is ignored in RUN and DRAIN.

Address rule:
- For stage s and butterfly b: tw_addr = (b & (2^s - 1)) << (LOG2N-1-s), truncated to ADDR_WIDTH+1 bits.
- Stage 0 always reads address 0.

Issue order and counters:
- Issue order: bfly increments 0..511 within a stage, then stage increments.
- Counters advance only on an issue cycle.

Issue condition and tags:
- Issue (tw_en=1) in RUN when (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready.
- The tag (stage, bfly, last) is captured with each issue.
- On the next cycle, tw_data and the delayed tag are written to the FIFO tail.

Output FIFO:
- 2-entry FIFO. m_valid = (fifo_count != 0). m_twiddle, m_stage, m_bfly and m_last come from the head.
- Data is registered from tw_data; there is no combinational path from tw_data to m_*.
- With m_ready held at 1, throughput is one word per cycle.
- First-word latency: start at cycle 0 -> tw_en at cycle 1 -> FIFO write at cycle 2 -> m_valid at cycle 3.
- Simultaneous push and pop keeps the count unchanged. The FIFO must never overflow; the issue condition guarantees this.
- Head outputs hold stable while m_valid=1 and m_ready=0.

Totals:
- Exactly LOG2N * 2^(LOG2N-1) = 5120 transfers per sweep, in issue order, with no loss or duplication under any m_ready pattern.
- m_last is asserted on exactly one transfer per sweep.

Test Plan:
- Reset then start, m_ready=1 → tw_en=1 at cycle 1 with tw_addr=0; m_valid at cycle 3. Then 5120 consecutive transfers, done exactly 1 cycle after the m_last transfer, busy low afterwards.
- Address check against a model ROM (entry i = {i, ~i}) → stage 3, bfly 5 carries address 320; stage 9, bfly 511 carries address 511; every stage-0 word carries address 0.
- Random m_ready (50%), plus m_ready held low for 20 cycles → FIFO count ≤ 2, held data stable, full sequence identical to the m_ready=1 run, at most 2 ROM reads outstanding while stalled.
- start pulsed during RUN at bfly 100 → ignored; the sweep continues and produces a single done.
- rst asserted mid-sweep at stage 4 → m_valid, busy and tw_en are 0 immediately. A new start then restarts from stage 0, bfly 0.
- Back-to-back sweeps: start on the cycle after done → second sweep begins cleanly, with m_stage=0 and m_bfly=0 on its first word.

Source files
------------

// File: rtl/fft_twiddle_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : fft_twiddle_fetch
//  Description : Twiddle ROM read sequencer for a radix-2 DIT FFT. Walks every
//                stage/butterfly, reads the ROM and streams tagged twiddles.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_twiddle_fetch #(
    parameter int TWIDDLE_WIDTH = 64,
    parameter int ADDR_WIDTH    = 8,
    parameter int LOG2N         = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     tw_en,
    output logic [ADDR_WIDTH:0]      tw_addr,
    input  logic [TWIDDLE_WIDTH-1:0] tw_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [TWIDDLE_WIDTH-1:0] m_twiddle,
    output logic [3:0]               m_stage,
    output logic [ADDR_WIDTH:0]      m_bfly,
    output logic                     m_last
);

    localparam int              c_BW         = ADDR_WIDTH + 1;
    localparam int              c_ENT_W      = TWIDDLE_WIDTH + 4 + c_BW + 1;
    localparam logic [3:0]      c_LAST_STAGE = 4'(LOG2N - 1);
    localparam logic [c_BW-1:0] c_LAST_BFLY  = '1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic [3:0]         r_stage;
    logic [c_BW-1:0]    r_bfly;
    logic               r_inflight;
    logic [3:0]         r_tag_stage;
    logic [c_BW-1:0]    r_tag_bfly;
    logic               r_tag_last;
    logic [c_ENT_W-1:0] r_mem [2];
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_count;
    logic               r_done;

    logic               w_pop;
    logic [2:0]         w_occ;
    logic               w_issue;
    logic [3:0]         w_shift;
    logic [c_BW-1:0]    w_mask;
    logic               w_is_last;
    logic [c_ENT_W-1:0] w_head;

    assign w_pop   = (r_count != 2'd0) && m_ready;
    // Slots committed after this edge: stored words plus the read in flight.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = (r_state == c_RUN) && (w_occ < 3'd2);

    // Twiddle index for stage s is (b mod 2^s) scaled by 2^(LOG2N-1-s).
    assign w_shift   = c_LAST_STAGE - r_stage;
    assign w_mask    = {c_BW{1'b1}} >> w_shift;
    assign tw_addr   = (r_bfly & w_mask) << w_shift;
    assign w_is_last = (r_stage == c_LAST_STAGE) && (r_bfly == c_LAST_BFLY);

    assign tw_en     = w_issue;
    assign busy      = (r_state != c_IDLE);
    assign done      = r_done;
    assign m_valid   = (r_count != 2'd0);
    assign w_head    = r_mem[r_rptr];
    assign m_twiddle = w_head[c_ENT_W-1 -: TWIDDLE_WIDTH];
    assign m_stage   = w_head[c_BW+1 +: 4];
    assign m_bfly    = w_head[1 +: c_BW];
    assign m_last    = w_head[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_stage <= '0;
            r_bfly  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_RUN;
                        r_stage <= '0;
                        r_bfly  <= '0;
                    end
                end
                c_RUN: begin
                    if (w_issue) begin
                        if (r_bfly == c_LAST_BFLY) begin
                            r_bfly <= '0;
                            if (r_stage == c_LAST_STAGE) begin
                                r_stage <= '0;
                                r_state <= c_DRAIN;
                            end else begin
                                r_stage <= r_stage + 4'd1;
                            end
                        end else begin
                            r_bfly <= r_bfly + 1'b1;
                        end
                    end
                end
                c_DRAIN: begin
                    if (w_pop && m_last) begin
                        r_state <= c_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Tag travels one cycle behind the read so it lines up with ROM data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight  <= 1'b0;
            r_tag_stage <= '0;
            r_tag_bfly  <= '0;
            r_tag_last  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag_stage <= r_stage;
                r_tag_bfly  <= r_bfly;
                r_tag_last  <= w_is_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= '0;
        end else begin
            if (r_inflight) begin
                r_mem[r_wptr] <= {tw_data, r_tag_stage, r_tag_bfly, r_tag_last};
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + 2'(r_inflight) - 2'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_twiddle_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_twiddle_fetch
//  Description : Scoreboard bench for fft_twiddle_fetch with a model ROM whose
//                entry i holds {i, ~i}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_twiddle_fetch;

    localparam int TW = 64;
    localparam int AW = 8;
    localparam int L  = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, tw_en, m_valid, m_ready, m_last;
    logic [AW:0]   tw_addr, m_bfly;
    logic [TW-1:0] tw_data, m_twiddle;
    logic [3:0]    m_stage;

    typedef struct packed {
        logic [TW-1:0] tw;
        logic [3:0]    st;
        logic [AW:0]   bf;
        logic          last;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;
    int   rmode  = 0;

    fft_twiddle_fetch #(.TWIDDLE_WIDTH(TW), .ADDR_WIDTH(AW), .LOG2N(L)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .tw_en(tw_en), .tw_addr(tw_addr), .tw_data(tw_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_twiddle(m_twiddle),
        .m_stage(m_stage), .m_bfly(m_bfly), .m_last(m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tw_en) tw_data <= {32'(tw_addr), ~32'(tw_addr)};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW:0] ref_addr(input int s, input int b);
        return (AW+1)'((b % (1 << s)) * (512 >> s));
    endfunction

    task automatic push_sweep();
        for (int s = 0; s < L; s++) begin
            for (int b = 0; b < 512; b++) begin
                logic [AW:0] a;
                a = ref_addr(s, b);
                sbq.push_back({{32'(a), ~32'(a)}, 4'(s), (AW+1)'(b), (s == L-1 && b == 511)});
            end
        end
    endtask

    // m_ready: mode 0 holds it high, mode 1 randomises it with a 20-cycle stall.
    initial begin
        int rcyc;
        rcyc    = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 1) begin
                rcyc++;
                if (rcyc >= 400 && rcyc < 420) m_ready = 1'b0;
                else m_ready = 1'($urandom_range(0, 1));
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    // Monitor: scoreboard pops, done alignment, stall stability, read depth.
    initial begin
        logic          last_d, stall_d, pop;
        logic [TW-1:0] hold_tw;
        logic [13:0]   hold_tag;
        int            issued, xfers;
        exp_t          e;
        last_d = 0; stall_d = 0; issued = 0; xfers = 0; hold_tw = '0; hold_tag = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_d = 0; stall_d = 0; issued = 0; xfers = 0;
            end else begin
                pop = m_valid && m_ready;
                if (done || last_d) chk("done_after_last", 64'(done), 64'(last_d));
                if (tw_en) chk("reads_outstanding_le2", 64'((issued - xfers + 1 - int'(pop)) <= 2), 64'd1);
                if (stall_d) begin
                    chk("stall_valid", 64'(m_valid), 64'd1);
                    chk("stall_twiddle", m_twiddle, hold_tw);
                    chk("stall_tag", 64'({m_stage, m_bfly, m_last}), 64'(hold_tag));
                end
                if (pop) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_word", 64'(m_bfly), 64'hFFFF);
                    end else begin
                        e = sbq.pop_front();
                        chk("twiddle", m_twiddle, e.tw);
                        chk("stage", 64'(m_stage), 64'(e.st));
                        chk("bfly", 64'(m_bfly), 64'(e.bf));
                        chk("last", 64'(m_last), 64'(e.last));
                        if (m_stage == 4'd3 && m_bfly == 9'd5) chk("addr_s3_b5", 64'(m_twiddle[63:32]), 64'd320);
                        if (m_stage == 4'd9 && m_bfly == 9'd511) chk("addr_s9_b511", 64'(m_twiddle[63:32]), 64'd511);
                    end
                end
                if (done) n_done++;
                last_d   = pop && m_last;
                stall_d  = m_valid && !m_ready;
                hold_tw  = m_twiddle;
                hold_tag = {m_stage, m_bfly, m_last};
                issued   = issued + int'(tw_en);
                xfers    = xfers + int'(pop);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit expect_sweep);
        start = 1'b1;
        if (expect_sweep) push_sweep();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        if (!done) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_word(input logic [3:0] st, input logic [AW:0] bf, input int max);
        int n;
        n = 0;
        while (!(m_valid && m_stage == st && m_bfly == bf) && n < max) begin
            tick();
            n++;
        end
        if (n >= max) chk("wait_word_timeout", 64'd0, 64'd1);
    endtask

    task automatic end_sweep(input int d0, input string tag);
        repeat (3) tick();
        chk({tag, "_single_done"}, 64'(n_done - d0), 64'd1);
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
        chk({tag, "_all_delivered"}, 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        int d0;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_tw_en", 64'(tw_en), 64'd0);
        chk("rst_tw_addr", 64'(tw_addr), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_outputs", 64'({m_twiddle[31:0], m_stage, m_bfly, m_last}), 64'd0);
        rst = 1'b0;
        tick();

        // Sweep 1: m_ready high, latency checks.
        d0 = n_done;
        pulse_start(1);
        chk("c1_tw_en", 64'(tw_en), 64'd1);
        chk("c1_tw_addr", 64'(tw_addr), 64'd0);
        chk("c1_busy", 64'(busy), 64'd1);
        chk("c1_m_valid", 64'(m_valid), 64'd0);
        tick();
        chk("c2_m_valid", 64'(m_valid), 64'd0);
        tick();
        chk("c3_m_valid", 64'(m_valid), 64'd1);
        wait_done(6000);
        chk("done_busy_low", 64'(busy), 64'd0);
        end_sweep(d0, "sweep1");

        // Sweep 2: random backpressure with a long stall.
        rmode = 1;
        d0 = n_done;
        pulse_start(1);
        wait_done(30000);
        rmode = 0;
        end_sweep(d0, "sweep2");

        // Sweep 3: start during RUN is ignored; back-to-back sweep follows.
        d0 = n_done;
        pulse_start(1);
        wait_word(4'd0, 9'd100, 500);
        pulse_start(0);
        wait_done(6000);
        pulse_start(1);
        wait_word(4'd0, 9'd0, 10);
        chk("b2b_first_stage", 64'(m_stage), 64'd0);
        chk("b2b_first_bfly", 64'(m_bfly), 64'd0);
        wait_done(6000);
        end_sweep(d0 + 1, "sweep3_4");

        // Sweep 5: abort at stage 4, then restart.
        d0 = n_done;
        pulse_start(1);
        wait_word(4'd4, 9'd0, 4000);
        rst = 1'b1;
        #1;
        chk("abort_m_valid", 64'(m_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_tw_en", 64'(tw_en), 64'd0);
        sbq.delete();
        tick();
        rst = 1'b0;
        tick();
        chk("abort_no_done", 64'(n_done - d0), 64'd0);
        pulse_start(1);
        chk("restart_tw_en", 64'(tw_en), 64'd1);
        chk("restart_tw_addr", 64'(tw_addr), 64'd0);
        wait_done(6000);
        end_sweep(d0, "sweep6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
